// File: rtl/shift_rows_serializer.sv
// AES ShiftRows stage that captures a full 128-bit state and streams it
// out one 32-bit column per handshake toward a column MixColumns stage.
// Each block carries a final-round tag so the next stage can skip MixColumns.
module shift_rows_serializer (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Data,
  input  logic         i_Last_Round,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [31:0]  o_Data,
  output logic [1:0]   o_Col,
  output logic         o_Col_Last,
  output logic         o_Last_Round
);

  localparam int unsigned NUM_COL = 4;
  localparam int unsigned COL_W   = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t       r_State;
  state_t       w_Next;
  logic [127:0] r_Hold;
  logic [127:0] w_Shift;
  logic [1:0]   r_Col;
  logic         r_Last_Round;
  logic         w_Accept;
  logic         w_Take;
  logic         w_Col_Last;

  // ShiftRows: output (row r, col c) takes input (row r, col (c+r) mod 4)
  always_comb begin
    w_Shift = '0;
    for (int unsigned c = 0; c < NUM_COL; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        w_Shift[127 - 8*(4*c + r) -: 8] = i_Data[127 - 8*(4*((c + r) % NUM_COL) + r) -: 8];
      end
    end
  end

  assign w_Col_Last = (r_Col == 2'd3);
  assign w_Accept   = i_Valid & o_Ready;
  assign w_Take     = o_Valid & i_Ready;

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_State <= IDLE;
    else       r_State <= w_Next;
  end

  // Next-state logic
  always_comb begin
    w_Next = r_State;
    case (r_State)
      IDLE: if (w_Accept) w_Next = SEND;
      SEND: if (w_Take && w_Col_Last) w_Next = w_Accept ? SEND : IDLE;
      default: w_Next = IDLE;
    endcase
  end

  // FSM outputs: ready reopens on the last-column handshake so blocks chain without a gap
  always_comb begin
    o_Valid = (r_State == SEND);
    o_Ready = (r_State == IDLE) | ((r_State == SEND) & w_Col_Last & i_Ready);
  end

  // Holding register, column counter and round tag
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Hold       <= '0;
      r_Col        <= '0;
      r_Last_Round <= 1'b0;
    end else if (w_Accept) begin
      r_Hold       <= w_Shift;
      r_Col        <= '0;
      r_Last_Round <= i_Last_Round;
    end else if (w_Take) begin
      r_Col <= r_Col + 2'd1;
    end
  end

  // Column select from the registered state only
  always_comb begin
    o_Data = '0;
    case (r_Col)
      2'd0: o_Data = r_Hold[4*COL_W-1 -: COL_W];
      2'd1: o_Data = r_Hold[3*COL_W-1 -: COL_W];
      2'd2: o_Data = r_Hold[2*COL_W-1 -: COL_W];
      2'd3: o_Data = r_Hold[1*COL_W-1 -: COL_W];
      default: o_Data = '0;
    endcase
  end

  assign o_Col        = r_Col;
  assign o_Col_Last   = w_Col_Last;
  assign o_Last_Round = r_Last_Round;

endmodule

// File: doc/shift_rows_serializer.md
Name: shift_rows_serializer

Overview:
- Upstream neighbour of the 32-bit column MixColumns stage in the AES round datapath.
- Accepts a full 128-bit post-SubBytes state and applies ShiftRows.
- Streams the result out one 32-bit column per handshake, in the column format the MixColumns stage consumes.
- Carries a final-round tag with each block so the downstream stage can bypass MixColumns in round 10.

Parameters:
- NUM_COL, 4, columns per state; fixed for AES and not to be overridden.
- COL_W, 32, column width in bits; fixed at 4 bytes.

Ports:
- i_Clk  input  1  clock; all state changes on the rising edge.
- i_Rst  input  1  synchronous, active-high reset.
- i_Valid  input  1  upstream block valid.
- o_Ready  output  1  block accepted when i_Valid & o_Ready.
- i_Data  input  128  state; byte k at [127-8k -: 8], column-major: byte k = row k%4, column k/4.
- i_Last_Round  input  1  final-round tag, captured with the block.
- o_Valid  output  1  column valid.
- i_Ready  input  1  downstream accepts a column when o_Valid & i_Ready.
- o_Data  output  32  shifted column: row0 [31:24], row1 [23:16], row2 [15:8], row3 [7:0].
- o_Col  output  2  index of the column currently presented (0..3).
- o_Col_Last  output  1  high when o_Col == 3.
- o_Last_Round  output  1  registered tag of the block being streamed.

Behaviour:
- ShiftRows mapping: output row r, column c = input row r, column (c+r) mod 4.
  - Computed combinationally at load.
  - Stored in a 128-bit holding register.
- States:
  - IDLE: no block held, o_Valid = 0.
  - SEND: block held, o_Valid = 1.
- o_Ready is combinational and equals IDLE | (SEND & o_Col_Last & i_Ready).
  - A new block therefore loads in the same cycle the last column of the previous block is taken.
- IDLE -> SEND on block accept at edge N.
  - Column 0 is presented from cycle N+1.
  - Latency is one cycle from accept to first column.
- In SEND, a column handshake advances o_Col by 1.
- On the handshake with o_Col == 3:
  - If a new block is also accepted, stay in SEND, load the new block and set o_Col = 0.
  - Otherwise go to IDLE and set o_Col = 0.
- i_Ready low in SEND: o_Data, o_Col, o_Last_Round and o_Valid are held stable.
  - No column is ever skipped or repeated.
- i_Valid while in SEND and not at the last-column handshake: ignored, because o_Ready = 0. Upstream must hold the block.
- o_Data, o_Col, o_Col_Last and o_Last_Round are driven from registers/state only (no combinational path from i_Data).
- Throughput:
  - 4 cycles per block with continuous i_Valid and i_Ready.
  - 5 cycles per block if upstream drops i_Valid between blocks.
- Reset (synchronous, takes priority over all other events):
  - state = IDLE, o_Valid = 0, o_Col = 0, o_Data = 0, o_Last_Round = 0, holding register = 0.
  - Reset mid-block discards the block; no partial columns are emitted afterwards.
  - o_Ready = 1 in the first cycle after reset deasserts.
- If reset and a handshake occur in the same cycle, reset wins and the handshake is lost.

Test Plan:
- Load 000102030405060708090a0b0c0d0e0f with i_Ready held high -> columns 00050a0f, 04090e03, 080d0207, 0c01060b on cycles N+1..N+4; o_Col = 0..3; o_Col_Last only on the 4th.
- Load FIPS-197 round-1 SubBytes state d42711aee0bf98f1b8b45de51e415230 -> d4bf5d30, e0b452ae, b84111f1, 1e2798e5; feeding column 0 to MixColumns yields 046681e5.
- Back-to-back blocks with i_Valid and i_Ready constantly high -> o_Valid never drops; block 2 column 0 appears the cycle after block 1 column 3; o_Ready pulses high on each last-column cycle.
- i_Ready low for 3 cycles while column 1 is presented -> o_Data and o_Col stay 1 and unchanged; stream resumes with column 2 with no loss or duplication.
- Assert i_Rst while column 2 is presented -> next cycle o_Valid = 0, o_Col = 0, o_Data = 0; the following block streams from column 0 correctly.
- i_Last_Round = 1 on block A and 0 on block B, back-to-back -> o_Last_Round is 1 for all 4 columns of A and 0 for all 4 columns of B.
